// File: rtl/linearb_hls_deadlock_reporter.sv
// Persistence filter over the HLS deadlock monitor `block` lines. It raises a sticky
// deadlock flag and hands out one timestamped report per episode over valid/ready.
module linearb_hls_deadlock_reporter #(
  parameter int N_MON  = 4,
  parameter int IDX_W  = 2,
  parameter int THRESH = 1024,
  parameter int CNT_W  = 11,
  parameter int TS_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_MON-1:0] monitor_block,
  input  logic             clear,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [IDX_W-1:0] report_idx,
  output logic [TS_W-1:0]  report_ts,
  output logic             deadlock,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, COUNT, REPORT, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TS_W-1:0]  ts_cnt;
  logic             any_block;
  logic [IDX_W-1:0] lowidx;

  // Scanning from the top down leaves the lowest set bit as the final winner.
  always_comb begin
    any_block = |monitor_block;
    lowidx    = '0;
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (monitor_block[i]) lowidx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ts_cnt       <= '0;
      report_valid <= 1'b0;
      report_idx   <= '0;
      report_ts    <= '0;
      deadlock     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      case (state)
        IDLE: begin
          if (any_block) begin
            state <= COUNT;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        COUNT: begin
          // Only continuity of any_block matters; the blocking set may shift freely.
          if (!any_block) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_W'(THRESH - 1)) begin
            state        <= REPORT;
            cnt          <= '0;
            busy         <= 1'b0;
            report_idx   <= lowidx;
            report_ts    <= ts_cnt;
            deadlock     <= 1'b1;
            report_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          if (report_ready) begin
            state        <= HOLD;
            report_valid <= 1'b0;
          end
        end
        HOLD: begin
          // Re-arm lands in IDLE even if a monitor is still blocked this cycle.
          if (clear) begin
            state    <= IDLE;
            deadlock <= 1'b0;
            cnt      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linearb_hls_deadlock_reporter.sv
// Table-driven bench with a scoreboard queue; a second instance with a 4-bit
// timestamp exercises the wrap behaviour.
module tb_linearb_hls_deadlock_reporter;

  logic        clock;
  logic        reset;
  logic [3:0]  monitor_block;
  logic        clear;
  logic        report_ready;
  logic        report_valid;
  logic [1:0]  report_idx;
  logic [31:0] report_ts;
  logic        deadlock;
  logic        busy;

  logic        w_reset;
  logic [3:0]  w_block;
  logic        w_clear;
  logic        w_ready;
  logic        w_valid;
  logic [1:0]  w_idx;
  logic [3:0]  w_ts;
  logic        w_deadlock;
  logic        w_busy;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  typedef struct {
    bit          wrap;
    bit          rst;
    logic [3:0]  mb;
    bit          clr;
    bit          rdy;
    bit          ev;
    logic [1:0]  eidx;
    logic [31:0] ets;
    bit          edl;
    bit          ebusy;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  linearb_hls_deadlock_reporter #(
    .N_MON(4), .IDX_W(2), .THRESH(4), .CNT_W(2), .TS_W(32)
  ) dut (
    .clock(clock), .reset(reset), .monitor_block(monitor_block), .clear(clear),
    .report_valid(report_valid), .report_ready(report_ready), .report_idx(report_idx),
    .report_ts(report_ts), .deadlock(deadlock), .busy(busy)
  );

  linearb_hls_deadlock_reporter #(
    .N_MON(4), .IDX_W(2), .THRESH(4), .CNT_W(2), .TS_W(4)
  ) dut_wrap (
    .clock(clock), .reset(w_reset), .monitor_block(w_block), .clear(w_clear),
    .report_valid(w_valid), .report_ready(w_ready), .report_idx(w_idx),
    .report_ts(w_ts), .deadlock(w_deadlock), .busy(w_busy)
  );

  always #5 clock = ~clock;

  // Independent transfer counter on the main instance.
  always @(posedge clock) begin
    if (!reset && report_valid && report_ready) xfers++;
  end

  task automatic add(input bit w, input bit rst, input logic [3:0] mb, input bit clr,
                     input bit rdy, input bit ev, input logic [1:0] idx,
                     input logic [31:0] ts, input bit dl, input bit bz);
    vec_t v;
    v.wrap = w; v.rst = rst; v.mb = mb; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.eidx = idx; v.ets = ts; v.edl = dl; v.ebusy = bz;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.wrap) begin
      w_reset = v.rst; w_block = v.mb; w_clear = v.clr; w_ready = v.rdy;
    end else begin
      reset = v.rst; monitor_block = v.mb; clear = v.clr; report_ready = v.rdy;
    end
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input int n);
    vec_t v;
    logic [36:0] act, exp;
    v = exp_q.pop_front();
    if (v.wrap) act = {w_valid, w_idx, 28'd0, w_ts, w_deadlock, w_busy};
    else        act = {report_valid, report_idx, report_ts, deadlock, busy};
    exp = {v.ev, v.eidx, v.ets, v.edl, v.ebusy};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL vec%0d: got valid=%0b idx=%0d ts=%0d dl=%0b busy=%0b, expected valid=%0b idx=%0d ts=%0d dl=%0b busy=%0b",
               n, act[36], act[35:34], act[33:2], act[1], act[0],
               v.ev, v.eidx, v.ets, v.edl, v.ebusy);
    end
  endtask

  initial begin
    clock = 0;
    reset = 1; monitor_block = 0; clear = 0; report_ready = 0;
    w_reset = 1; w_block = 0; w_clear = 0; w_ready = 0;

    // Reset, then idle through timestamps 0..9.
    add(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    // Basic detection: monitor 2 blocked on edges with timestamps 10..13.
    for (int i = 0; i < 3; i++) add(0, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 4'b0100, 0, 0, 1, 2, 13, 1, 0);
    // Stalled handshake, clear ignored in REPORT, then the transfer and one HOLD cycle.
    for (int i = 0; i < 5; i++) add(0, 0, 4'b0000, (i == 2), 0, 1, 2, 13, 1, 0);
    add(0, 0, 4'b0000, 0, 1, 0, 2, 13, 1, 0);
    add(0, 0, 4'b0000, 0, 0, 0, 2, 13, 1, 0);
    // Clear in HOLD with monitor 0 still blocked lands in IDLE; re-detect on edges 22..25.
    add(0, 0, 4'b0001, 1, 0, 0, 2, 13, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 4'b0001, 0, 0, 0, 2, 13, 0, 1);
    add(0, 0, 4'b0001, 0, 0, 1, 0, 25, 1, 0);
    add(0, 0, 4'b0000, 0, 1, 0, 0, 25, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 25, 0, 0);
    // Gap after three blocked edges restarts the count; the second burst reports at 35.
    for (int i = 0; i < 3; i++) add(0, 0, 4'b1100, 0, 0, 0, 0, 25, 0, 1);
    add(0, 0, 4'b0000, 0, 0, 0, 0, 25, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 4'b1100, 0, 0, 0, 0, 25, 0, 1);
    add(0, 0, 4'b1100, 0, 0, 1, 2, 35, 1, 0);
    // Still blocked through transfer and HOLD: no new detection while deadlock is set.
    add(0, 0, 4'b1100, 0, 1, 0, 2, 35, 1, 0);
    add(0, 0, 4'b1100, 0, 0, 0, 2, 35, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 2, 35, 0, 0);
    // Blocking set shifts mid-count (clear ignored in COUNT); report at 42 with idx 1.
    add(0, 0, 4'b1000, 0, 0, 0, 2, 35, 0, 1);
    add(0, 0, 4'b1000, 1, 0, 0, 2, 35, 0, 1);
    add(0, 0, 4'b0010, 0, 0, 0, 2, 35, 0, 1);
    add(0, 0, 4'b0010, 0, 0, 1, 1, 42, 1, 0);
    // Reset mid-handshake clears everything; timestamp restarts so the next report is 3.
    add(0, 0, 4'b0000, 0, 0, 1, 1, 42, 1, 0);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 4'b1000, 0, 0, 1, 3, 3, 1, 0);
    // 4-bit timestamp instance: detect at 15, then again after the wrap at 0.
    add(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) add(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 4'b1000, 0, 0, 1, 3, 15, 1, 0);
    add(1, 0, 4'b0000, 0, 1, 0, 3, 15, 1, 0);
    add(1, 0, 4'b0000, 1, 0, 0, 3, 15, 0, 0);
    for (int i = 0; i < 11; i++) add(1, 0, 4'b0000, 0, 0, 0, 3, 15, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 4'b0001, 0, 0, 0, 3, 15, 0, 1);
    add(1, 0, 4'b0001, 0, 0, 1, 0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(posedge clock);
      #1;
      checkOutput(i);
    end

    checks++;
    if (xfers != 3) begin
      failures++;
      $display("[TB] FAIL transfer_count: got %0d, expected 3", xfers);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/linearb_hls_deadlock_reporter.md
Name: lineArb_hls_deadlock_reporter

Overview:
Consumer end of the per-instance HLS deadlock monitors. It collects the `block` outputs of up to N_MON monitors and applies a persistence filter. A deadlock is declared only when some monitor stays blocked for THRESH consecutive cycles. It then raises a sticky flag and delivers one report (blocking monitor index plus cycle timestamp) over a valid/ready handshake to the debug/status logic.

Parameters:
N_MON, 4, number of monitor `block` inputs (1..32)
IDX_W, 2, width of reported index, ceil(log2(N_MON)) with minimum 1
THRESH, 1024, consecutive blocked cycles before a deadlock is declared (>=2)
CNT_W, 11, persistence counter width, must hold THRESH-1
TS_W, 32, timestamp width

Ports:
clock  in  1  single clock; all logic is rising-edge
reset  in  1  synchronous, active-high reset
monitor_block  in  N_MON  bit i = `block` output of monitor i
clear  in  1  single-cycle pulse; re-arms the detector after a report
report_valid  out  1  report available
report_ready  in  1  downstream accepts report
report_idx  out  IDX_W  lowest-numbered blocking monitor at detection
report_ts  out  TS_W  free-running cycle count at detection
deadlock  out  1  sticky deadlock flag
busy  out  1  high in COUNT state (blocking seen, not yet confirmed)

Behaviour:
- Reset (synchronous, any state, mid-handshake included):
  - state=IDLE, persistence cnt=0, timestamp counter=0.
  - report_valid=0, report_idx=0, report_ts=0, deadlock=0, busy=0.
- Timestamp counter:
  - Increments every non-reset cycle.
  - Wraps modulo 2^TS_W with no flag.
- any_block = OR of monitor_block.
- lowidx = index of the lowest set bit of monitor_block.
- IDLE:
  - If any_block: go to COUNT, cnt=1, capture lowidx.
  - clear has no effect.
- COUNT (busy=1):
  - If !any_block: go to IDLE, cnt=0. Any gap restarts the count.
  - Else if cnt==THRESH-1: go to REPORT.
    - report_idx=current lowidx.
    - report_ts=pre-increment timestamp value.
    - deadlock=1.
  - Else: cnt+1 and refresh captured lowidx. The set of blocking monitors may change; only continuity of any_block matters.
  - clear is ignored.
- Detection latency: any_block must be sampled high on THRESH consecutive edges. deadlock and report_valid become 1 after the THRESH-th such edge.
- REPORT:
  - report_valid=1.
  - report_idx and report_ts stay stable until report_valid&report_ready is sampled; then go to HOLD, report_valid=0 on the next cycle.
  - report_ready may be held high in advance. Transfer then occurs on the first REPORT cycle.
  - clear in REPORT is ignored; the report must complete.
  - monitor_block is ignored.
- HOLD:
  - deadlock stays 1; report_idx and report_ts keep their last values.
  - On clear: go to IDLE, deadlock=0, cnt=0.
  - If any_block is high in the same cycle as clear, the detector goes to IDLE, not COUNT. Counting starts on the next sampled edge.
- Exactly one report per deadlock episode. No new detection while deadlock=1.
- N_MON bits above the valid width do not exist. report_idx is zero-extended when N_MON < 2^IDX_W.

Test Plan:
1. THRESH=4, reset, then monitor_block=4'b0100 held for 4 edges from timestamp 10:
   - deadlock=1 and report_valid=1 with report_idx=2, report_ts=13.
   - busy=1 for 3 cycles before that.
2. THRESH=4, monitor_block high 3 edges, low 1, high 4:
   - No report after the first burst; busy drops to 0.
   - Report fires only after the 4th edge of the second burst.
3. Blocking set changes mid-count (4'b1000 for 2 edges, then 4'b0010 for 2 edges), THRESH=4:
   - Count is continuous; report_idx=1.
4. Handshake: report_ready=0 for 5 cycles after report_valid, then 1:
   - idx and ts stable throughout; single transfer; report_valid=0 next cycle.
   - clear pulsed during REPORT is ignored; deadlock stays 1.
5. clear in HOLD with monitor_block=4'b0001 still high:
   - deadlock=0 next cycle, state IDLE.
   - Re-detection after 4 further edges gives report_idx=0.
6. reset asserted while report_valid=1 and ready=0:
   - Next cycle all outputs are 0 and the timestamp restarts at 0.
   - Timestamp wrap check with TS_W=4: a detection at count 15 reports 15 and the following count reads 0.
